// File: rtl/imem_loader.sv
// Boot-time instruction memory: assembles a little-endian byte stream into 32-bit words,
// holds the core in reset until the program is in place, then serves fetches combinationally.
module imem_loader #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        reload,
  input  logic [7:0]  imem_addr,
  output logic [31:0] imem_data,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        overflow
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] shift_word_q;
  logic [8:0]  wr_ptr_q;
  logic [8:0]  words_loaded_q;
  logic        core_rst_n_q;
  logic        load_done_q;
  logic        overflow_q;
  logic [31:0] mem [DEPTH];

  logic        accept_s;
  logic        word_wr_s;
  logic [31:0] asm_word_d;
  logic [8:0]  wr_ptr_d;
  logic [31:0] imem_data_s;

  // Handshake qualification and word assembly; upper lanes stay zero because the shift
  // register is cleared after every word write.
  always_comb begin
    accept_s   = load_valid & (state_q == ST_LOAD);
    word_wr_s  = accept_s & ((byte_cnt_q == 2'd3) | load_last);
    wr_ptr_d   = wr_ptr_q + 9'd1;
    asm_word_d = shift_word_q;
    asm_word_d[8*byte_cnt_q +: 8] = load_data;
  end

  // Loader FSM with registered core reset, done and overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_LOAD;
      byte_cnt_q     <= 2'd0;
      shift_word_q   <= 32'd0;
      wr_ptr_q       <= 9'd0;
      words_loaded_q <= 9'd0;
      core_rst_n_q   <= 1'b0;
      load_done_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (word_wr_s) begin
            shift_word_q   <= 32'd0;
            byte_cnt_q     <= 2'd0;
            wr_ptr_q       <= wr_ptr_d;
            words_loaded_q <= wr_ptr_d;
            if (load_last || (wr_ptr_d == DEPTH_W)) begin
              state_q      <= ST_RUN;
              core_rst_n_q <= 1'b1;
              load_done_q  <= 1'b1;
              overflow_q   <= ~load_last;
            end
          end else if (accept_s) begin
            shift_word_q <= asm_word_d;
            byte_cnt_q   <= byte_cnt_q + 2'd1;
          end
        end
        ST_RUN: begin
          if (reload) begin
            state_q        <= ST_LOAD;
            core_rst_n_q   <= 1'b0;
            load_done_q    <= 1'b0;
            wr_ptr_q       <= 9'd0;
            words_loaded_q <= 9'd0;
            byte_cnt_q     <= 2'd0;
            shift_word_q   <= 32'd0;
            overflow_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // Instruction array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (word_wr_s) begin
      mem[wr_ptr_q[AW-1:0]] <= asm_word_d;
    end
  end

  // Fetch port: anything not yet counted as loaded reads back as a NOP.
  always_comb begin
    if ({1'b0, imem_addr} < words_loaded_q) begin
      imem_data_s = mem[imem_addr[AW-1:0]];
    end else begin
      imem_data_s = NOP_WORD;
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;
  assign imem_data  = imem_data_s;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (DEPTH=4): load, partial word, stall, overflow, reload, reset mid-load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        core_rst_n;
  logic        load_done;
  logic        overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  imem_loader #(.DEPTH(4), .NOP_WORD(32'h00000013)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .reload     (reload),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = b;
    load_last  = last;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    imem_addr = a;
    #1;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    chk_cnt++; if (core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n got %b exp 0", core_rst_n); else pass_cnt++;
    chk_cnt++; if (load_done !== 1'b0) $display("FAIL rst_load_done got %b exp 0", load_done); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b exp 0", overflow); else pass_cnt++;
    chk_cnt++; if (load_ready !== 1'b1) $display("FAIL rst_load_ready got %b exp 1", load_ready); else pass_cnt++;
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL rst_fetch0 got %h exp 00000013", imem_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_load();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    for (int i = 0; i < 7; i++) send(prog[i], 1'b0);
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h00100013) $display("FAIL basic_partial_w0 got %h exp 00100013", imem_data); else pass_cnt++;
    fetch(8'd1);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL basic_partial_w1 got %h exp 00000013", imem_data); else pass_cnt++;
    chk_cnt++; if (core_rst_n !== 1'b0) $display("FAIL basic_core_held got %b exp 0", core_rst_n); else pass_cnt++;
    send(prog[7], 1'b1);
    chk_cnt++; if (core_rst_n !== 1'b1) $display("FAIL basic_core_rel got %b exp 1", core_rst_n); else pass_cnt++;
    chk_cnt++; if (load_done !== 1'b1) $display("FAIL basic_done got %b exp 1", load_done); else pass_cnt++;
    chk_cnt++; if (load_ready !== 1'b0) $display("FAIL basic_ready got %b exp 0", load_ready); else pass_cnt++;
    fetch(8'd1);
    chk_cnt++; if (imem_data !== 32'h00200093) $display("FAIL basic_w1 got %h exp 00200093", imem_data); else pass_cnt++;
    fetch(8'd2);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL basic_w2_nop got %h exp 00000013", imem_data); else pass_cnt++;
    fetch(8'd255);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL basic_w255_nop got %h exp 00000013", imem_data); else pass_cnt++;
  endtask

  task automatic test_reload_partial();
    pulse_reload();
    chk_cnt++; if (core_rst_n !== 1'b0) $display("FAIL reload_core_rst got %b exp 0", core_rst_n); else pass_cnt++;
    chk_cnt++; if (load_ready !== 1'b1) $display("FAIL reload_ready got %b exp 1", load_ready); else pass_cnt++;
    chk_cnt++; if (load_done !== 1'b0) $display("FAIL reload_done got %b exp 0", load_done); else pass_cnt++;
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL reload_fetch0 got %h exp 00000013", imem_data); else pass_cnt++;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk_cnt++; if (load_done !== 1'b1) $display("FAIL partial_done got %b exp 1", load_done); else pass_cnt++;
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h00CCBBAA) $display("FAIL partial_w0 got %h exp 00ccbbaa", imem_data); else pass_cnt++;
    fetch(8'd1);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL partial_w1_nop got %h exp 00000013", imem_data); else pass_cnt++;
  endtask

  task automatic test_stall();
    pulse_reload();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reload = (i == 2);
    end
    @(negedge clk);
    reload = 1'b0;
    chk_cnt++; if (load_ready !== 1'b1) $display("FAIL stall_ready got %b exp 1", load_ready); else pass_cnt++;
    chk_cnt++; if (core_rst_n !== 1'b0) $display("FAIL stall_core_rst got %b exp 0", core_rst_n); else pass_cnt++;
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b1);
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h44332211) $display("FAIL stall_w0 got %h exp 44332211", imem_data); else pass_cnt++;
    fetch(8'd1);
    chk_cnt++; if (imem_data !== 32'h00000055) $display("FAIL last_lane0_w1 got %h exp 00000055", imem_data); else pass_cnt++;
    chk_cnt++; if (load_done !== 1'b1) $display("FAIL stall_done got %b exp 1", load_done); else pass_cnt++;
  endtask

  task automatic test_overflow();
    pulse_reload();
    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", overflow); else pass_cnt++;
      end
      send(8'(8'h40 + i), 1'b0);
      if (i == 15) begin
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else pass_cnt++;
        chk_cnt++; if (load_ready !== 1'b0) $display("FAIL ovf_ready got %b exp 0", load_ready); else pass_cnt++;
        chk_cnt++; if (load_done !== 1'b1) $display("FAIL ovf_done got %b exp 1", load_done); else pass_cnt++;
      end
    end
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h43424140) $display("FAIL ovf_w0 got %h exp 43424140", imem_data); else pass_cnt++;
    fetch(8'd3);
    chk_cnt++; if (imem_data !== 32'h4F4E4D4C) $display("FAIL ovf_w3 got %h exp 4f4e4d4c", imem_data); else pass_cnt++;
    fetch(8'd4);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL ovf_w4_nop got %h exp 00000013", imem_data); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else pass_cnt++;
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL reload_ovf_clr got %b exp 0", overflow); else pass_cnt++;
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    fetch(8'd0);
    chk_cnt++; if (imem_data !== 32'h04030201) $display("FAIL mid_w0 got %h exp 04030201", imem_data); else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL mid_rst_fetch got %h exp 00000013", imem_data); else pass_cnt++;
    chk_cnt++; if (load_ready !== 1'b1 || core_rst_n !== 1'b0 || load_done !== 1'b0 || overflow !== 1'b0)
      $display("FAIL mid_rst_outs got ready=%b core=%b done=%b ovf=%b exp 1 0 0 0", load_ready, core_rst_n, load_done, overflow);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (imem_data !== 32'h00000013) $display("FAIL mid_rel_fetch got %h exp 00000013", imem_data); else pass_cnt++;
    chk_cnt++; if (load_ready !== 1'b1) $display("FAIL mid_rel_ready got %b exp 1", load_ready); else pass_cnt++;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_data  = 8'h00;
    load_valid = 1'b0;
    load_last  = 1'b0;
    reload     = 1'b0;
    imem_addr  = 8'h00;
    test_reset();
    test_basic_load();
    test_reload_partial();
    test_stall();
    test_overflow();
    test_reset_midload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
